data_mem_responder: RTL

- Data-side memory responder on the CPU load/store port. It answers the stage-3 MEM_addr / MEM_type / MEM_rd_en / MEM_wr_en requests from the pipeline.
- Contains a word-organised RAM with byte-lane stores and same-cycle extended load data.
- Also decodes a small MMIO window: a free-running cycle counter plus sticky fault capture for misaligned, conflicting and out-of-range accesses.
- The pipeline has no stall path, so every access completes in the cycle it is presented.

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-side load/store responder: word RAM with byte-lane stores, zero-latency
// extended loads, and an MMIO window with a cycle counter and sticky fault capture.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_cycle;
  logic [31:0] r_fault_addr;
  logic [2:0]  r_status;

  logic [AW-1:0] w_idx;
  logic          w_in_ram;
  logic          w_in_mmio;
  logic          w_unaligned;
  logic          w_misalign;
  logic          w_conflict;
  logic          w_access;
  logic [2:0]    w_fault_bits;
  logic          w_clear;
  logic          w_ram_we;
  logic          w_rd_ok;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // Address decode and access legality
  assign w_idx      = MEM_addr[AW+1:2];
  assign w_in_ram   = (MEM_addr[31:AW+2] == '0);
  assign w_in_mmio  = (MEM_addr[31:4] == MMIO_BASE[31:4]);
  assign w_access   = MEM_rd_en | MEM_wr_en;
  assign w_conflict = MEM_rd_en & MEM_wr_en;

  always_comb begin
    w_unaligned = 1'b1;
    case (MEM_type)
      T_B, T_BU: w_unaligned = 1'b0;
      T_H, T_HU: w_unaligned = MEM_addr[0];
      T_W:       w_unaligned = |MEM_addr[1:0];
      default:   w_unaligned = 1'b1;
    endcase
  end

  // MMIO registers are word-only; any other size there is treated as misaligned
  assign w_misalign   = w_unaligned | (w_in_mmio & (MEM_type != T_W));
  assign w_fault_bits = w_access ? {~w_in_ram & ~w_in_mmio, w_conflict, w_misalign} : 3'b000;
  assign w_clear      = MEM_wr_en & ~MEM_rd_en & w_in_mmio & ~w_misalign
                      & (MEM_addr[3:0] == 4'h8);
  assign w_ram_we     = MEM_wr_en & ~MEM_rd_en & ~w_misalign & w_in_ram;
  assign w_rd_ok      = MEM_rd_en & ~MEM_wr_en & ~w_misalign;

  // Store lane steering: replicate the right-justified data across lanes
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = MEM_WR_out;
    case (MEM_type[1:0])
      2'b00: begin
        w_be    = 4'b0001 << MEM_addr[1:0];
        w_wdata = {4{MEM_WR_out[7:0]}};
      end
      2'b01: begin
        w_be    = MEM_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{MEM_WR_out[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = MEM_WR_out;
      end
    endcase
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{MEM_addr[1:0], 3'b000} +: 8];
  assign w_half = MEM_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    MEM_data = 32'd0;
    if (w_rd_ok && w_in_ram) begin
      case (MEM_type)
        T_B:     MEM_data = {{24{w_byte[7]}}, w_byte};
        T_H:     MEM_data = {{16{w_half[15]}}, w_half};
        T_W:     MEM_data = w_word;
        T_BU:    MEM_data = {24'd0, w_byte};
        T_HU:    MEM_data = {16'd0, w_half};
        default: MEM_data = 32'd0;
      endcase
    end else if (w_rd_ok && w_in_mmio) begin
      case (MEM_addr[3:2])
        2'd0:    MEM_data = r_cycle;
        2'd1:    MEM_data = r_fault_addr;
        2'd2:    MEM_data = {29'd0, r_status};
        default: MEM_data = 32'd0;
      endcase
    end
  end

  // RAM is not reset; a store presented while reset is low is dropped
  always_ff @(posedge CLK or negedge rst) begin
    if (rst && w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Cycle counter and sticky fault state; a STATUS clear beats any capture
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_cycle      <= 32'd0;
      r_status     <= 3'd0;
      r_fault_addr <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_clear) begin
        r_status     <= 3'd0;
        r_fault_addr <= 32'd0;
      end else if (|w_fault_bits) begin
        r_status <= r_status | w_fault_bits;
        if (r_status == 3'd0) r_fault_addr <= MEM_addr;
      end
    end
  end

  assign fault      = |r_status;
  assign fault_addr = r_fault_addr;

endmodule
